// File: rtl/rv32i_reorder_buffer.sv
// Reorder buffer for the RV32I out-of-order core.
// The dispatcher allocates entries at the tail, and writeback marks them done
// in any order. At most one done entry retires from the head per cycle, in
// program order, and drives the register file's retire inputs.
module rv32i_reorder_buffer #(
    parameter int ROB_DEPTH   = 16,
    parameter int ARCH_IDX_BW = 5,
    parameter int PHYS_IDX_BW = 6,
    parameter int ROB_IDX_BW  = $clog2(ROB_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_disp_vld,
    input  logic                   i_disp_dst_vld,
    input  logic [ARCH_IDX_BW-1:0] i_disp_arch_rf_idx,
    input  logic [PHYS_IDX_BW-1:0] i_disp_phys_rf_idx,
    output logic                   o_disp_rdy,
    output logic [ROB_IDX_BW-1:0]  o_disp_rob_idx,
    input  logic                   i_wb_vld,
    input  logic [ROB_IDX_BW-1:0]  i_wb_rob_idx,
    output logic                   o_retire,
    output logic                   o_retire_dst_vld,
    output logic [ARCH_IDX_BW-1:0] o_retire_arch_rf_idx,
    output logic [PHYS_IDX_BW-1:0] o_retire_phys_rf_idx,
    output logic [ROB_IDX_BW:0]    o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam logic [ROB_IDX_BW:0]   FULL_COUNT = (ROB_IDX_BW+1)'(ROB_DEPTH);
    localparam logic [ROB_IDX_BW-1:0] PTR_ONE    = ROB_IDX_BW'(1);

    // Per-entry status bits need a reset; the payload fields do not, because
    // they are only read while the matching valid bit is set.
    logic [ROB_DEPTH-1:0]   valid_q;
    logic [ROB_DEPTH-1:0]   done_q;
    logic                   dst_vld_q [ROB_DEPTH];
    logic [ARCH_IDX_BW-1:0] arch_q    [ROB_DEPTH];
    logic [PHYS_IDX_BW-1:0] phys_q    [ROB_DEPTH];

    logic [ROB_IDX_BW-1:0]  head;
    logic [ROB_IDX_BW-1:0]  tail;
    logic [ROB_IDX_BW:0]    count;

    logic                   disp_fire;
    logic                   retire_fire;
    logic [ARCH_IDX_BW-1:0] disp_arch;
    logic [PHYS_IDX_BW-1:0] disp_phys;

    // Occupancy flags come from the counter, since head == tail is ambiguous.
    // A slot freed by a retire only opens dispatch on the following cycle.
    always_comb begin
        o_full         = (count == FULL_COUNT);
        o_empty        = (count == '0);
        o_count        = count;
        o_disp_rdy     = !o_full;
        o_disp_rob_idx = tail;
        disp_fire      = i_disp_vld && !o_full;
        retire_fire    = valid_q[head] && done_q[head];
        disp_arch      = i_disp_dst_vld ? i_disp_arch_rf_idx : '0;
        disp_phys      = i_disp_dst_vld ? i_disp_phys_rf_idx : '0;
    end

    // Pointers, status bits, occupancy and the registered retire port.
    // Flush behaves exactly like reset and wins over every other event.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            valid_q              <= '0;
            done_q               <= '0;
            head                 <= '0;
            tail                 <= '0;
            count                <= '0;
            o_retire             <= 1'b0;
            o_retire_dst_vld     <= 1'b0;
            o_retire_arch_rf_idx <= '0;
            o_retire_phys_rf_idx <= '0;
        end else begin
            if (i_wb_vld && valid_q[i_wb_rob_idx]) begin
                done_q[i_wb_rob_idx] <= 1'b1;
            end

            if (retire_fire) begin
                valid_q[head]        <= 1'b0;
                done_q[head]         <= 1'b0;
                head                 <= head + PTR_ONE;
                o_retire             <= 1'b1;
                o_retire_dst_vld     <= dst_vld_q[head];
                o_retire_arch_rf_idx <= arch_q[head];
                o_retire_phys_rf_idx <= phys_q[head];
            end else begin
                o_retire         <= 1'b0;
                o_retire_dst_vld <= 1'b0;
            end

            if (disp_fire) begin
                valid_q[tail] <= 1'b1;
                done_q[tail]  <= 1'b0;
                tail          <= tail + PTR_ONE;
            end

            case ({disp_fire, retire_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Capture the destination payload of an accepted dispatch.
    always_ff @(posedge clk) begin
        if (disp_fire && !i_flush && !rst) begin
            dst_vld_q[tail] <= i_disp_dst_vld;
            arch_q[tail]    <= disp_arch;
            phys_q[tail]    <= disp_phys;
        end
    end

endmodule

// File: tb/tb_rv32i_reorder_buffer.sv
// Directed testbench for rv32i_reorder_buffer with hand-computed expectations.
module tb_rv32i_reorder_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_flush;
    logic       i_disp_vld;
    logic       i_disp_dst_vld;
    logic [4:0] i_disp_arch_rf_idx;
    logic [5:0] i_disp_phys_rf_idx;
    logic       o_disp_rdy;
    logic [3:0] o_disp_rob_idx;
    logic       i_wb_vld;
    logic [3:0] i_wb_rob_idx;
    logic       o_retire;
    logic       o_retire_dst_vld;
    logic [4:0] o_retire_arch_rf_idx;
    logic [5:0] o_retire_phys_rf_idx;
    logic [4:0] o_count;
    logic       o_empty;
    logic       o_full;

    int checkCount = 0;
    int errorCount = 0;

    rv32i_reorder_buffer dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_flush              (i_flush),
        .i_disp_vld           (i_disp_vld),
        .i_disp_dst_vld       (i_disp_dst_vld),
        .i_disp_arch_rf_idx   (i_disp_arch_rf_idx),
        .i_disp_phys_rf_idx   (i_disp_phys_rf_idx),
        .o_disp_rdy           (o_disp_rdy),
        .o_disp_rob_idx       (o_disp_rob_idx),
        .i_wb_vld             (i_wb_vld),
        .i_wb_rob_idx         (i_wb_rob_idx),
        .o_retire             (o_retire),
        .o_retire_dst_vld     (o_retire_dst_vld),
        .o_retire_arch_rf_idx (o_retire_arch_rf_idx),
        .o_retire_phys_rf_idx (o_retire_phys_rf_idx),
        .o_count              (o_count),
        .o_empty              (o_empty),
        .o_full               (o_full)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and log mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then step to 1 time unit past the rising edge.
    task automatic applyStimulus(input logic disp_vld, input logic dst_vld,
                                 input logic [4:0] arch, input logic [5:0] phys,
                                 input logic wb_vld, input logic [3:0] wb_idx,
                                 input logic flush);
        i_disp_vld         = disp_vld;
        i_disp_dst_vld     = dst_vld;
        i_disp_arch_rf_idx = arch;
        i_disp_phys_rf_idx = phys;
        i_wb_vld           = wb_vld;
        i_wb_rob_idx       = wb_idx;
        i_flush            = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        idleCycle();
        idleCycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_flush = 1'b0;
        i_disp_vld = 1'b0;
        i_disp_dst_vld = 1'b0;
        i_disp_arch_rf_idx = '0;
        i_disp_phys_rf_idx = '0;
        i_wb_vld = 1'b0;
        i_wb_rob_idx = '0;
        $display("[TB] start");

        // Reset state
        applyReset();
        checkOutput("rst_count", 32'(o_count), 32'd0);
        checkOutput("rst_empty", 32'(o_empty), 32'd1);
        checkOutput("rst_full", 32'(o_full), 32'd0);
        checkOutput("rst_rdy", 32'(o_disp_rdy), 32'd1);
        checkOutput("rst_retire", 32'(o_retire), 32'd0);
        checkOutput("rst_rob_idx", 32'(o_disp_rob_idx), 32'd0);
        checkOutput("rst_arch", 32'(o_retire_arch_rf_idx), 32'd0);

        // Three instructions, completed out of order 2, 0, 1
        for (int i = 0; i < 3; i++) begin
            checkOutput("ooo_alloc_idx", 32'(o_disp_rob_idx), 32'(i));
            applyStimulus(1'b1, 1'b1, 5'(i + 1), 6'(33 + i), 1'b0, 4'd0, 1'b0);
        end
        checkOutput("ooo_count3", 32'(o_count), 32'd3);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 4'd2, 1'b0);
        checkOutput("ooo_no_retire_wb2", 32'(o_retire), 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 4'd0, 1'b0);
        checkOutput("ooo_no_bypass", 32'(o_retire), 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 4'd1, 1'b0);
        checkOutput("ooo_ret0", 32'(o_retire), 32'd1);
        checkOutput("ooo_ret0_dst", 32'(o_retire_dst_vld), 32'd1);
        checkOutput("ooo_ret0_arch", 32'(o_retire_arch_rf_idx), 32'd1);
        checkOutput("ooo_ret0_phys", 32'(o_retire_phys_rf_idx), 32'd33);
        checkOutput("ooo_count2", 32'(o_count), 32'd2);
        idleCycle();
        checkOutput("ooo_ret1", 32'(o_retire), 32'd1);
        checkOutput("ooo_ret1_arch", 32'(o_retire_arch_rf_idx), 32'd2);
        checkOutput("ooo_ret1_phys", 32'(o_retire_phys_rf_idx), 32'd34);
        idleCycle();
        checkOutput("ooo_ret2", 32'(o_retire), 32'd1);
        checkOutput("ooo_ret2_arch", 32'(o_retire_arch_rf_idx), 32'd3);
        checkOutput("ooo_ret2_phys", 32'(o_retire_phys_rf_idx), 32'd35);
        checkOutput("ooo_count0", 32'(o_count), 32'd0);
        checkOutput("ooo_empty", 32'(o_empty), 32'd1);
        idleCycle();
        checkOutput("ooo_ret_done", 32'(o_retire), 32'd0);
        checkOutput("ooo_hold_arch", 32'(o_retire_arch_rf_idx), 32'd3);

        // Fill all 16 entries with no writeback
        applyReset();
        for (int i = 0; i < 16; i++) begin
            checkOutput("fill_alloc_idx", 32'(o_disp_rob_idx), 32'(i));
            applyStimulus(1'b1, 1'b1, 5'(i + 10), 6'(i + 20), 1'b0, 4'd0, 1'b0);
        end
        checkOutput("fill_full", 32'(o_full), 32'd1);
        checkOutput("fill_count", 32'(o_count), 32'd16);
        checkOutput("fill_rdy", 32'(o_disp_rdy), 32'd0);
        applyStimulus(1'b1, 1'b1, 5'd31, 6'd63, 1'b0, 4'd0, 1'b0);
        checkOutput("fill_17th_count", 32'(o_count), 32'd16);
        checkOutput("fill_17th_tail", 32'(o_disp_rob_idx), 32'd0);

        // Full: writeback head with dispatch held; slot opens a cycle after retire
        applyStimulus(1'b1, 1'b1, 5'd30, 6'd60, 1'b1, 4'd0, 1'b0);
        checkOutput("fullwb_count", 32'(o_count), 32'd16);
        checkOutput("fullwb_rdy", 32'(o_disp_rdy), 32'd0);
        checkOutput("fullwb_retire", 32'(o_retire), 32'd0);
        applyStimulus(1'b1, 1'b1, 5'd30, 6'd60, 1'b0, 4'd0, 1'b0);
        checkOutput("fullret_retire", 32'(o_retire), 32'd1);
        checkOutput("fullret_arch", 32'(o_retire_arch_rf_idx), 32'd10);
        checkOutput("fullret_phys", 32'(o_retire_phys_rf_idx), 32'd20);
        checkOutput("fullret_count", 32'(o_count), 32'd15);
        checkOutput("fullret_rdy", 32'(o_disp_rdy), 32'd1);
        checkOutput("fullret_idx", 32'(o_disp_rob_idx), 32'd0);
        applyStimulus(1'b1, 1'b1, 5'd30, 6'd60, 1'b0, 4'd0, 1'b0);
        checkOutput("refill_count", 32'(o_count), 32'd16);
        checkOutput("refill_full", 32'(o_full), 32'd1);
        checkOutput("refill_tail", 32'(o_disp_rob_idx), 32'd1);
        checkOutput("refill_retire", 32'(o_retire), 32'd0);

        // Reset mid-operation with a writeback to an in-flight entry
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 4'd1, 1'b0);
        rst = 1'b0;
        checkOutput("midrst_count", 32'(o_count), 32'd0);
        checkOutput("midrst_empty", 32'(o_empty), 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 4'(i + 1), 1'b0);
            checkOutput("midrst_no_retire", 32'(o_retire), 32'd0);
        end

        // Steady stream of 20: dispatch k, writeback k next cycle, retire after
        applyReset();
        for (int k = 0; k < 22; k++) begin
            if (k < 20) begin
                checkOutput("wrap_alloc_idx", 32'(o_disp_rob_idx), 32'(k % 16));
            end
            applyStimulus(k < 20, 1'b1, 5'(k + 1), 6'(40 + k),
                          (k >= 1) && (k <= 20), 4'((k + 15) % 16), 1'b0);
            checkOutput("wrap_count_le16", 32'(o_count <= 5'd16), 32'd1);
            if (k < 2) begin
                checkOutput("wrap_no_retire", 32'(o_retire), 32'd0);
            end else begin
                checkOutput("wrap_retire", 32'(o_retire), 32'd1);
                checkOutput("wrap_ret_arch", 32'(o_retire_arch_rf_idx), 32'(k - 1));
                checkOutput("wrap_ret_phys", 32'(o_retire_phys_rf_idx), 32'(38 + k));
            end
        end
        checkOutput("wrap_final_count", 32'(o_count), 32'd0);

        // Flush drops a pending retire and every in-flight entry
        applyReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 5'(i + 1), 6'(i + 1), 1'b0, 4'd0, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 4'd1, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 4'd2, 1'b1);
        checkOutput("flush_count", 32'(o_count), 32'd0);
        checkOutput("flush_retire", 32'(o_retire), 32'd0);
        checkOutput("flush_empty", 32'(o_empty), 32'd1);
        checkOutput("flush_tail", 32'(o_disp_rob_idx), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 4'(i), 1'b0);
            checkOutput("flush_no_retire", 32'(o_retire), 32'd0);
        end

        // DST retire, then a non-DST retire whose idx fields must read 0
        applyStimulus(1'b1, 1'b1, 5'd7, 6'd50, 1'b0, 4'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 4'd0, 1'b0);
        idleCycle();
        checkOutput("dst_retire", 32'(o_retire), 32'd1);
        checkOutput("dst_ret_arch", 32'(o_retire_arch_rf_idx), 32'd7);
        checkOutput("dst_ret_phys", 32'(o_retire_phys_rf_idx), 32'd50);
        checkOutput("nodst_alloc_idx", 32'(o_disp_rob_idx), 32'd1);
        applyStimulus(1'b1, 1'b0, 5'd5, 6'd9, 1'b0, 4'd0, 1'b0);
        checkOutput("hold_retire", 32'(o_retire), 32'd0);
        checkOutput("hold_dst_vld", 32'(o_retire_dst_vld), 32'd0);
        checkOutput("hold_arch", 32'(o_retire_arch_rf_idx), 32'd7);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 4'd7, 1'b0);
        checkOutput("wb7_count", 32'(o_count), 32'd1);
        checkOutput("wb7_retire", 32'(o_retire), 32'd0);
        idleCycle();
        checkOutput("wb7_still_no_retire", 32'(o_retire), 32'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 6'd0, 1'b1, 4'd1, 1'b0);
        checkOutput("nodst_wb_cycle", 32'(o_retire), 32'd0);
        idleCycle();
        checkOutput("nodst_retire", 32'(o_retire), 32'd1);
        checkOutput("nodst_dst_vld", 32'(o_retire_dst_vld), 32'd0);
        checkOutput("nodst_arch", 32'(o_retire_arch_rf_idx), 32'd0);
        checkOutput("nodst_phys", 32'(o_retire_phys_rf_idx), 32'd0);
        checkOutput("nodst_empty", 32'(o_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/rv32i_reorder_buffer.md
Name: rv32i_reorder_buffer

Overview:
In-order retirement buffer for the RV32I out-of-order core. The dispatcher allocates one entry per instruction, and writeback marks entries complete in any order. The block retires at most one completed instruction per cycle from the head, in program order. Its retire port drives the register file's retire inputs (retire strobe, DST valid, arch/phys index), which reclaim stale physical tags and mark RAT entries committed.

Parameters:
ROB_DEPTH, 16, number of entries; must be a power of 2, at least 2
ARCH_IDX_BW, 5, architectural register index width
PHYS_IDX_BW, 6, physical register tag width
ROB_IDX_BW, $clog2(ROB_DEPTH), entry index width (derived; not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
i_flush  in  1  discard all in-flight entries
i_disp_vld  in  1  dispatcher presents an instruction
i_disp_dst_vld  in  1  instruction writes a destination register
i_disp_arch_rf_idx  in  ARCH_IDX_BW  destination arch register
i_disp_phys_rf_idx  in  PHYS_IDX_BW  destination phys tag from RF
o_disp_rdy  out  1  entry available (combinational, = !o_full)
o_disp_rob_idx  out  ROB_IDX_BW  index allocated on acceptance (= tail pointer)
i_wb_vld  in  1  writeback completion strobe
i_wb_rob_idx  in  ROB_IDX_BW  entry being completed
o_retire  out  1  registered retire strobe
o_retire_dst_vld  out  1  retired instruction had a DST
o_retire_arch_rf_idx  out  ARCH_IDX_BW  retired arch register
o_retire_phys_rf_idx  out  PHYS_IDX_BW  retired phys tag
o_count  out  ROB_IDX_BW+1  occupied entries
o_empty  out  1  o_count == 0
o_full  out  1  o_count == ROB_DEPTH

Behaviour:
- Reset is synchronous, active-high. On reset:
  - all entry valid and done bits are cleared;
  - head = tail = 0 and o_count = 0;
  - o_retire, o_retire_dst_vld, o_retire_arch_rf_idx and o_retire_phys_rf_idx are 0;
  - o_empty = 1, o_full = 0, o_disp_rdy = 1.
- Entry contents: valid, done, dst_vld, arch idx, phys idx.
- Dispatch:
  - Accepted when i_disp_vld & o_disp_rdy.
  - On acceptance, write entry[tail] with valid = 1, done = 0 and the dst fields, then advance tail by 1 modulo ROB_DEPTH.
  - When i_disp_dst_vld = 0, the stored idx fields are don't-care and are forced to 0.
  - i_disp_vld while full is ignored. The dispatcher must hold the instruction until o_disp_rdy is high.
- Writeback:
  - i_wb_vld sets entry[i_wb_rob_idx].done = 1 only if that entry is valid; otherwise the strobe is ignored.
  - Completion may arrive in any order.
- Retire:
  - Retire occurs in a cycle where entry[head] is valid and done.
  - At the next edge: o_retire <= 1; o_retire_* <= entry fields; entry[head].valid <= 0; head advances by 1 modulo ROB_DEPTH.
  - Otherwise o_retire <= 0 and o_retire_dst_vld <= 0; idx outputs hold their value.
  - Retire latency: a writeback at edge N makes the entry done, so o_retire is high after edge N+1. There is no same-cycle writeback-to-retire bypass.
  - Retire throughput is at most one entry per cycle.
- Count rules:
  - Dispatch and retire in the same cycle leave o_count unchanged.
  - Dispatch alone increments o_count; retire alone decrements it.
  - When full, o_disp_rdy = 0 even if a retire happens that cycle. A freed slot becomes visible in the next cycle.
- Wrap-around: head and tail wrap from ROB_DEPTH-1 to 0 naturally. Full vs. empty is determined by o_count, not by pointer equality.
- Simultaneous events:
  - Dispatch to entry[tail] and writeback to a different index update independently.
  - Writeback to the head entry in the same cycle it is being dispatched is impossible, because the entry is not yet valid, so the writeback is ignored.
- Flush:
  - i_flush has priority over dispatch, writeback and retire in the same cycle.
  - Next edge: identical to reset, including o_retire <= 0, so a pending retire is dropped.
- Reset mid-operation: all in-flight entries are discarded, with no retire pulses afterward until new dispatches complete.

Test Plan:
- Reset then dispatch 3 entries, with phys tags 33, 34, 35 to arch regs 1, 2, 3. Write back idx 2, then 0, then 1. Required response:
  - o_retire pulses for idx 0 (arch 1 / phys 33) one cycle after the wb of idx 0;
  - then idx 1 and idx 2 retire on consecutive cycles;
  - o_count returns to 0 and o_empty = 1.
- Dispatch 16 entries with no writeback → o_full = 1, o_count = 16, o_disp_rdy = 0. A 17th i_disp_vld is ignored and tail stays at 0.
- Wrap: dispatch and retire 20 instructions in a steady stream. Required response:
  - o_disp_rob_idx sequence 0..15, 0..3;
  - retire order matches dispatch order;
  - o_count never exceeds 16.
- Full ROB, then write back the head and simultaneously raise i_disp_vld → dispatch is blocked that cycle. The head retires, then next cycle o_disp_rdy = 1 and dispatch is accepted at idx 0.
- Dispatch 4 entries and write back 2 of them, then assert i_flush together with a completing wb → next cycle o_count = 0, o_retire = 0, and no later retire pulses.
- Non-DST instruction (i_disp_dst_vld = 0), then wb → o_retire = 1 with o_retire_dst_vld = 0 and idx outputs 0. A wb to an unallocated idx 7 causes no state change.
